// File: rtl/param_logic_unit_if.sv
// Operand/result handshake bundle for param_logic_unit.
// The slave modport is the unit's view; the master modport is the producer/consumer side.
interface param_logic_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [2:0]       op;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, x, y, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, f, zero, parity, count
    );

    modport slave (
        input  in_valid, x, y, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, f, zero, parity, count
    );
endinterface

// File: rtl/param_logic_unit.sv
// Registered WIDTH-bit bitwise logic unit with a runtime opcode, a one-deep output
// register under valid/ready backpressure, result feedback accumulator, flags and op counter.
module param_logic_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    param_logic_unit_if.slave   bus
);

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (o)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return ~a;
            3'b011:  return ~(a & b);
            3'b100:  return ~(a | b);
            3'b101:  return a ^ b;
            3'b110:  return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] f_q, f_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;

    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] res;

    // Ready looks straight through to out_ready so a full register can stream without a bubble.
    assign bus.in_ready = rst_n & (~out_valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign consume      = out_valid_q & bus.out_ready;

    // A clear issued together with accumulate selects zero rather than the stale accumulator.
    assign b_sel = bus.acc_en ? (bus.acc_clr ? '0 : acc_q) : bus.y;
    assign res   = logic_op(bus.op, bus.x, b_sel);

    always_comb begin
        f_d         = f_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        if (accept) begin
            f_d         = res;
            zero_d      = ~|res;
            parity_d    = ^res;
            out_valid_d = 1'b1;
            acc_d       = res;
            count_d     = sat_inc(count_q);
        end else begin
            if (consume) begin
                out_valid_d = 1'b0;
            end
            if (bus.acc_clr) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q         <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            parity_q    <= 1'b0;
        end else begin
            f_q         <= f_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_param_logic_unit.sv
// Scoreboard bench for param_logic_unit: a wide-counter instance for the datapath
// and a 2-bit-counter instance for saturation and mid-transaction reset.
module tb_param_logic_unit;

    logic clk;
    logic rst_n;
    logic rst_n2;

    param_logic_unit_if #(.WIDTH(8), .CNT_W(16)) bus  ();
    param_logic_unit_if #(.WIDTH(8), .CNT_W(2))  bus2 ();

    param_logic_unit #(.WIDTH(8), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
    param_logic_unit #(.WIDTH(8), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n2), .bus(bus2));

    typedef struct {
        logic [7:0]  f;
        logic        z;
        logic        p;
        logic [15:0] c;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [15:0] cnt1;
    logic [15:0] cnt2;
    int          n_checks;
    int          n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input int w, input logic v, input logic [2:0] o, input logic [7:0] xa,
                         input logic [7:0] ya, input logic ae, input logic ac);
        if (w == 1) begin
            bus.in_valid = v; bus.op = o; bus.x = xa; bus.y = ya; bus.acc_en = ae; bus.acc_clr = ac;
        end else begin
            bus2.in_valid = v; bus2.op = o; bus2.x = xa; bus2.y = ya; bus2.acc_en = ae; bus2.acc_clr = ac;
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 1) ? bus.in_ready : bus2.in_ready;
    endfunction

    // Present one operation, wait (bounded) for acceptance, then queue its expected result.
    task automatic send(input int w, input logic [2:0] o, input logic [7:0] xa, input logic [7:0] ya,
                        input logic ae, input logic ac, input logic [7:0] ef, input logic ep);
        int   n;
        exp_t e;
        drive(w, 1'b1, o, xa, ya, ae, ac);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy(w) && n < 50);
        if (!rdy(w)) begin
            chk("accept_timeout", {31'd0, rdy(w)}, 32'd1);
            drive(w, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
            return;
        end
        @(posedge clk);
        if (w == 1) begin
            cnt1 = (cnt1 == 16'hFFFF) ? cnt1 : cnt1 + 16'd1;
            e = '{f: ef, z: (ef == 8'd0), p: ep, c: cnt1};
            q1.push_back(e);
        end else begin
            cnt2 = (cnt2 == 16'd3) ? cnt2 : cnt2 + 16'd1;
            e = '{f: ef, z: (ef == 8'd0), p: ep, c: cnt2};
            q2.push_back(e);
        end
        #1;
        drive(w, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (q1.size() == 0) chk("m1_unexpected_out", {31'd0, bus.out_valid}, 32'd0);
            else begin
                e = q1.pop_front();
                chk("m1_f",      {24'd0, bus.f},      {24'd0, e.f});
                chk("m1_zero",   {31'd0, bus.zero},   {31'd0, e.z});
                chk("m1_parity", {31'd0, bus.parity}, {31'd0, e.p});
                chk("m1_count",  {16'd0, bus.count},  {16'd0, e.c});
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (bus2.out_valid === 1'b1 && bus2.out_ready === 1'b1) begin
            if (q2.size() == 0) chk("m2_unexpected_out", {31'd0, bus2.out_valid}, 32'd0);
            else begin
                e = q2.pop_front();
                chk("m2_f",      {24'd0, bus2.f},      {24'd0, e.f});
                chk("m2_zero",   {31'd0, bus2.zero},   {31'd0, e.z});
                chk("m2_parity", {31'd0, bus2.parity}, {31'd0, e.p});
                chk("m2_count",  {30'd0, bus2.count},  {16'd0, e.c});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        n_checks = 0; n_pass = 0; cnt1 = 16'd0; cnt2 = 16'd0;
        rst_n = 1'b0; rst_n2 = 1'b0;
        drive(1, 1'b1, 3'b111, 8'h55, 8'h00, 1'b0, 1'b0);
        drive(2, 1'b1, 3'b111, 8'h55, 8'h00, 1'b0, 1'b0);
        bus.out_ready = 1'b1; bus2.out_ready = 1'b1;

        // Reset held two cycles with in_valid high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_f",         {24'd0, bus.f},         32'h00);
        chk("rst_zero",      {31'd0, bus.zero},      32'd1);
        chk("rst_parity",    {31'd0, bus.parity},    32'd0);
        chk("rst_count",     {16'd0, bus.count},     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; rst_n2 = 1'b1;
        drive(1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        drive(2, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);

        // First accept after release carries count=1.
        send(1, 3'b111, 8'h81, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; cnt1 = 16'd0;

        // Opcode sweep, back-to-back.
        send(1, 3'b000, 8'hC5, 8'h3C, 1'b0, 1'b0, 8'h04, 1'b1);
        send(1, 3'b001, 8'hC5, 8'h3C, 1'b0, 1'b0, 8'hFD, 1'b1);
        send(1, 3'b010, 8'hC5, 8'h3C, 1'b0, 1'b0, 8'h3A, 1'b0);
        send(1, 3'b011, 8'hC5, 8'h3C, 1'b0, 1'b0, 8'hFB, 1'b1);
        send(1, 3'b100, 8'hC5, 8'h3C, 1'b0, 1'b0, 8'h02, 1'b1);
        send(1, 3'b101, 8'hC5, 8'h3C, 1'b0, 1'b0, 8'hF9, 1'b0);
        send(1, 3'b110, 8'hC5, 8'h3C, 1'b0, 1'b0, 8'h06, 1'b0);
        send(1, 3'b111, 8'hC5, 8'h3C, 1'b0, 1'b0, 8'hC5, 1'b0);
        @(negedge clk);
        chk("sweep_count", {16'd0, bus.count}, 32'd8);
        @(posedge clk); #1;

        // Backpressure: first result held, second input stalled.
        bus.out_ready = 1'b0;
        send(1, 3'b000, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0);
        drive(1, 1'b1, 3'b001, 8'h10, 8'h01, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
            chk("bp_f_hold",    {24'd0, bus.f},         32'h0F);
            chk("bp_count",     {16'd0, bus.count},     32'd9);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(1, 3'b001, 8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 1'b0);

        // Accumulate chain.
        send(1, 3'b101, 8'hA5, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0);
        send(1, 3'b101, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0);
        send(1, 3'b101, 8'h5A, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

        // Clear without accept.
        send(1, 3'b111, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0);
        drive(1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        send(1, 3'b001, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);

        // Counter saturation on the 2-bit instance.
        send(2, 3'b111, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1);
        send(2, 3'b111, 8'h03, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0);
        send(2, 3'b101, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 1'b0);
        send(2, 3'b000, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(2, 3'b001, 8'h80, 8'h01, 1'b0, 1'b0, 8'h81, 1'b0);

        // Reset while a result is held.
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;
        send(2, 3'b010, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        chk("held_out_valid", {31'd0, bus2.out_valid}, 32'd1);
        chk("held_f",         {24'd0, bus2.f},         32'hFF);
        @(posedge clk); #1;
        rst_n2 = 1'b0;
        @(posedge clk); #1;
        rst_n2 = 1'b1;
        q2.delete();
        cnt2 = 16'd0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, bus2.out_valid}, 32'd0);
        chk("midrst_f",         {24'd0, bus2.f},         32'h00);
        chk("midrst_count",     {30'd0, bus2.count},     32'd0);
        chk("midrst_zero",      {31'd0, bus2.zero},      32'd1);
        bus2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
